line_buf_write_ctrl: RTL and testbench

//   Write-side counterpart of the 4:1 line-buffer read mux. Accepts a raster pixel stream and

---
 rtl/line_buf_write_ctrl.sv | 142 ++++++++++++++
 tb/tb_line_buf_write_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/line_buf_write_ctrl.sv
// Write-side controller for a bank of four rotating line buffers.
// Accepts a raster pixel stream, writes each line into the current buffer,
// rotates to the next buffer every LINE_W pixels and tracks how many complete
// lines are held against a downstream reader. It also drives the matching
// read-mux select so that the reader always sees the oldest complete line.
module line_buf_write_ctrl #(
   parameter int DATA_W = 8,
   parameter int LINE_W = 512,
   parameter int COL_W  = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_pix_valid,
   input  logic [DATA_W-1:0] i_pix_data,
   output logic              o_ready,
   input  logic              i_rd_line_done,
   output logic [3:0]        o_wr_en,
   output logic [COL_W-1:0]  o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   output logic [1:0]        o_rd_sel,
   output logic              o_rows_ready,
   output logic              o_line_done,
   output logic              o_drop
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LINE = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);

   logic [1:0]        state_reg, state_next;
   logic [1:0]        wr_ptr_reg, wr_ptr_next;
   logic [1:0]        rd_ptr_reg, rd_ptr_next;
   logic [COL_W-1:0]  col_reg, col_next;
   logic [2:0]        fill_cnt_reg, fill_cnt_next;
   logic [3:0]        wr_en_reg;
   logic [COL_W-1:0]  wr_addr_reg;
   logic [DATA_W-1:0] wr_data_reg;
   logic [1:0]        rd_sel_reg;
   logic              rows_ready_reg;
   logic              line_done_reg;
   logic              drop_reg;

   logic accept;
   logic line_complete;
   logic rd_release;

   // All four buffers full means the writer must stall until the reader frees one.
   assign o_ready       = (fill_cnt_reg != 3'd4);
   assign accept        = i_pix_valid & o_ready;
   assign line_complete = accept & (col_reg == LAST_COL);
   // A release request with nothing buffered has nothing to free and is ignored.
   assign rd_release    = i_rd_line_done & (fill_cnt_reg != 3'd0);

   // Next-state for pointers, column, occupancy and the line FSM.
   always_comb begin
      col_next      = col_reg;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      fill_cnt_next = fill_cnt_reg;
      state_next    = state_reg;

      if (accept) begin
         col_next = line_complete ? '0 : col_reg + 1'b1;
      end
      if (line_complete) begin
         wr_ptr_next = wr_ptr_reg + 2'd1;
      end
      if (rd_release) begin
         rd_ptr_next = rd_ptr_reg + 2'd1;
      end
      // Simultaneous completion and release cancel out in the occupancy count.
      if (line_complete && !rd_release) begin
         fill_cnt_next = fill_cnt_reg + 3'd1;
      end else if (rd_release && !line_complete) begin
         fill_cnt_next = fill_cnt_reg - 3'd1;
      end

      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               state_next = S_LINE;
            end
         end
         S_LINE: begin
            if (line_complete) begin
               state_next = (fill_cnt_next == 3'd4) ? S_FULL : S_IDLE;
            end
         end
         S_FULL: begin
            if (i_rd_line_done) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State and registered outputs; writes land one cycle after the accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         wr_ptr_reg     <= 2'd0;
         rd_ptr_reg     <= 2'd0;
         col_reg        <= '0;
         fill_cnt_reg   <= 3'd0;
         wr_en_reg      <= 4'b0000;
         wr_addr_reg    <= '0;
         wr_data_reg    <= '0;
         rd_sel_reg     <= 2'b10;
         rows_ready_reg <= 1'b0;
         line_done_reg  <= 1'b0;
         drop_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         col_reg        <= col_next;
         fill_cnt_reg   <= fill_cnt_next;
         wr_en_reg      <= accept ? (4'b0001 << wr_ptr_reg) : 4'b0000;
         if (accept) begin
            wr_addr_reg <= col_reg;
            wr_data_reg <= i_pix_data;
         end
         // Buffer k sits on read-mux input k^2, so the select is the flipped pointer.
         rd_sel_reg     <= rd_ptr_next ^ 2'b10;
         rows_ready_reg <= (fill_cnt_next >= 3'd3);
         line_done_reg  <= line_complete;
         drop_reg       <= i_pix_valid & ~o_ready;
      end
   end

   assign o_wr_en      = wr_en_reg;
   assign o_wr_addr    = wr_addr_reg;
   assign o_wr_data    = wr_data_reg;
   assign o_rd_sel     = rd_sel_reg;
   assign o_rows_ready = rows_ready_reg;
   assign o_line_done  = line_done_reg;
   assign o_drop       = drop_reg;

endmodule

// File: tb/tb_line_buf_write_ctrl.sv
// Bench for line_buf_write_ctrl with a 4-pixel line: a vector table for the
// main streaming/full/wrap sequence plus hand-written corner sequences.
module tb_line_buf_write_ctrl;

   localparam int DATA_W = 8;
   localparam int LINE_W = 4;
   localparam int COL_W  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pix_valid = 1'b0;
   logic [DATA_W-1:0] pix_data = '0;
   logic              rd_line_done = 1'b0;
   logic              ready;
   logic [3:0]        wr_en;
   logic [COL_W-1:0]  wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        rd_sel;
   logic              rows_ready;
   logic              line_done;
   logic              drop;

   int checks = 0;
   int errors = 0;

   line_buf_write_ctrl #(.DATA_W(DATA_W), .LINE_W(LINE_W), .COL_W(COL_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_pix_valid    (pix_valid),
      .i_pix_data     (pix_data),
      .o_ready        (ready),
      .i_rd_line_done (rd_line_done),
      .o_wr_en        (wr_en),
      .o_wr_addr      (wr_addr),
      .o_wr_data      (wr_data),
      .o_rd_sel       (rd_sel),
      .o_rows_ready   (rows_ready),
      .o_line_done    (line_done),
      .o_drop         (drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       rd_done;
      logic [3:0] exp_wr_en;
      logic [1:0] exp_addr;
      logic       exp_line_done;
      logic       exp_drop;
      logic       exp_ready;
      logic [1:0] exp_rd_sel;
      logic       exp_rows;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic rd,
                      input logic [3:0] we, input logic [1:0] a, input logic ld,
                      input logic dr, input logic rdy, input logic [1:0] sel, input logic rows);
      vec_t t;
      t.valid = v; t.data = d; t.rd_done = rd; t.exp_wr_en = we; t.exp_addr = a;
      t.exp_line_done = ld; t.exp_drop = dr; t.exp_ready = rdy; t.exp_rd_sel = sel;
      t.exp_rows = rows;
      vecs.push_back(t);
   endtask

   // Apply one cycle of inputs and sample just after the active edge.
   task automatic step(input logic v, input logic [7:0] d, input logic rd);
      pix_valid = v; pix_data = d; rd_line_done = rd;
      @(posedge clk);
      #1;
      pix_valid = 1'b0; rd_line_done = 1'b0;
   endtask

   task automatic check_vec(input int idx, input vec_t t);
      string tag;
      tag = $sformatf("v%0d", idx);
      chk({tag, "_wr_en"}, 32'(wr_en), 32'(t.exp_wr_en));
      if (t.exp_wr_en != 4'b0000) begin
         chk({tag, "_addr"}, 32'(wr_addr), 32'(t.exp_addr));
         chk({tag, "_data"}, 32'(wr_data), 32'(t.data));
      end
      chk({tag, "_line_done"}, 32'(line_done), 32'(t.exp_line_done));
      chk({tag, "_drop"}, 32'(drop), 32'(t.exp_drop));
      chk({tag, "_ready"}, 32'(ready), 32'(t.exp_ready));
      chk({tag, "_rd_sel"}, 32'(rd_sel), 32'(t.exp_rd_sel));
      chk({tag, "_rows_ready"}, 32'(rows_ready), 32'(t.exp_rows));
      $display("vec %0d: valid=%0b data=%02h rd=%0b -> wr_en=%04b addr=%0d ld=%0b drop=%0b rdy=%0b sel=%02b rows=%0b",
               idx, t.valid, t.data, t.rd_done, wr_en, wr_addr, line_done, drop, ready, rd_sel, rows_ready);
   endtask

   // Write a full line starting at base; the last pixel can carry a read release.
   task automatic hand_line(input string name, input logic [7:0] base, input logic [3:0] exp_we,
                            input logic rd_on_last);
      for (int p = 0; p < LINE_W; p++) begin
         step(1'b1, base + 8'(p), (p == LINE_W - 1) ? rd_on_last : 1'b0);
         chk({name, "_wr_en"}, 32'(wr_en), 32'(exp_we));
         chk({name, "_addr"}, 32'(wr_addr), p);
         chk({name, "_data"}, 32'(wr_data), 32'(base + 8'(p)));
         chk({name, "_line_done"}, 32'(line_done), (p == LINE_W - 1) ? 32'd1 : 32'd0);
         $display("%s pix %0d: wr_en=%04b addr=%0d data=%02h ld=%0b", name, p, wr_en, wr_addr, wr_data, line_done);
      end
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_wr_en"}, 32'(wr_en), 32'd0);
      chk({name, "_addr"}, 32'(wr_addr), 32'd0);
      chk({name, "_data"}, 32'(wr_data), 32'd0);
      chk({name, "_line_done"}, 32'(line_done), 32'd0);
      chk({name, "_drop"}, 32'(drop), 32'd0);
      chk({name, "_rows_ready"}, 32'(rows_ready), 32'd0);
      chk({name, "_rd_sel"}, 32'(rd_sel), 32'h2);
      chk({name, "_ready"}, 32'(ready), 32'd1);
      $display("%s: wr_en=%04b addr=%0d data=%02h sel=%02b rdy=%0b rows=%0b", name, wr_en, wr_addr, wr_data, rd_sel, ready, rows_ready);
   endtask

   initial begin
      // Release with nothing buffered is ignored.
      add(0, 8'h00, 1, 4'b0000, 0, 0, 0, 1, 2'b10, 0);
      // Four lines into buffers 0..3, no reads; third line makes a 3x3 window available.
      for (int l = 0; l < 4; l++) begin
         for (int p = 0; p < LINE_W; p++) begin
            add(1, 8'(8'h10 * (l + 1) + p), 0, 4'(4'b0001 << l), 2'(p), (p == 3),
                0, !((l == 3) && (p == 3)), 2'b10, (l >= 3) || ((l == 2) && (p == 3)));
         end
      end
      // Full: offered pixel is dropped with no write.
      add(1, 8'h5F, 0, 4'b0000, 0, 0, 1, 0, 2'b10, 1);
      // One release frees buffer 0 and moves the read select on.
      add(0, 8'h00, 1, 4'b0000, 0, 0, 0, 1, 2'b11, 1);
      // Fifth line wraps back into buffer 0 and fills the bank again.
      for (int p = 0; p < LINE_W; p++) begin
         add(1, 8'(8'h50 + p), 0, 4'b0001, 2'(p), (p == 3), 0, (p != 3), 2'b11, 1);
      end

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].valid, vecs[i].data, vecs[i].rd_done);
         check_vec(i, vecs[i]);
      end

      // Now fill=4, rd_ptr=1, wr_ptr=1. Two releases take fill to 2.
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("drain_rd_sel", 32'(rd_sel), 32'h1);
      chk("drain_rows_ready", 32'(rows_ready), 32'd0);
      chk("drain_ready", 32'(ready), 32'd1);
      // Completion and release together: occupancy stays 2, both pointers advance.
      hand_line("same_cycle", 8'h60, 4'b0010, 1'b1);
      chk("same_cycle_rd_sel", 32'(rd_sel), 32'h2);
      chk("same_cycle_rows_ready", 32'(rows_ready), 32'd0);
      // One more line lands in buffer 2 and takes occupancy to 3.
      hand_line("after_same", 8'h70, 4'b0100, 1'b0);
      chk("after_same_rows_ready", 32'(rows_ready), 32'd1);
      chk("after_same_ready", 32'(ready), 32'd1);

      // Reset in the middle of a line, away from the clock edge.
      step(1'b1, 8'hA0, 1'b0);
      step(1'b1, 8'hA1, 1'b0);
      chk("mid_line_addr", 32'(wr_addr), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("async_reset");
      @(posedge clk);
      #2;
      rst = 1'b0;
      #2;
      hand_line("post_reset", 8'hB0, 4'b0001, 1'b0);
      chk("post_reset_rd_sel", 32'(rd_sel), 32'h2);
      chk("post_reset_rows_ready", 32'(rows_ready), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
